// File: rtl/line_arb_pkg.sv
// Shared types for the line command arbiter.
//   line_cmd_t  : one line request {x0, y0, x1, y1, color}
//   arb_state_e : arbiter FSM states
// X_W / Y_W are the default coordinate widths used by line_cmd_t.
package line_arb_pkg;

    localparam int unsigned X_W = 10;
    localparam int unsigned Y_W = 9;

    typedef struct packed {
        logic [X_W-1:0] x0;
        logic [Y_W-1:0] y0;
        logic [X_W-1:0] x1;
        logic [Y_W-1:0] y1;
        logic           color;
    } line_cmd_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DRAW  = 2'd2,
        ACK   = 2'd3
    } arb_state_e;

endpackage

// File: rtl/line_cmd_arbiter_rr_arbiter.sv
// Round-robin pick: first set request at or after ptr, wrapping NUM_REQ-1 -> 0.
// Purely combinational; the caller owns and advances ptr.
// Ports:
//   req   in  NUM_REQ  request vector
//   ptr   in  IDX_W    highest-priority index
//   grant out NUM_REQ  one-hot grant (all zero when no request)
//   idx   out IDX_W    index of the granted request
//   valid out 1        at least one request present
module rr_arbiter #(
    parameter  int unsigned NUM_REQ = 2,
    localparam int unsigned IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   idx,
    output logic               valid
);

    logic [IDX_W-1:0] cand;

    // Scan from ptr upward; the first hit wins.
    always_comb begin
        grant = '0;
        idx   = '0;
        valid = 1'b0;
        cand  = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (!valid) begin
                cand = IDX_W'((32'(ptr) + i) % NUM_REQ);
                if (req[cand]) begin
                    grant[cand] = 1'b1;
                    idx         = cand;
                    valid       = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/line_cmd_arbiter.sv
// Shares one line_drawer between NUM_REQ line-command requesters.
// Round-robin grant, command latch, one-cycle drawer start, wait for done,
// one-cycle ack to the winner.
// Optional feature: define LINE_ARB_TIMEOUT_EN to abort a line after TIMEOUT
// DRAW cycles and raise a sticky timeout_err.
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   req / req_cmd       per-requester request and command
//   ack                 one-cycle completion pulse for the served requester
//   drw_start           one-cycle pulse to line_drawer tempReset
//   drw_x0..drw_y1      latched endpoints, drw_color latched color
//   drw_done            line_drawer done
//   busy                high outside IDLE
//   timeout_err         sticky abort flag (0 without LINE_ARB_TIMEOUT_EN)
module line_cmd_arbiter
    import line_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned X_W     = line_arb_pkg::X_W,
    parameter int unsigned Y_W     = line_arb_pkg::Y_W,
    parameter int unsigned TIMEOUT = 1048576
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_REQ-1:0]     req,
    input  line_cmd_t [NUM_REQ-1:0] req_cmd,
    output logic [NUM_REQ-1:0]     ack,
    output logic                   drw_start,
    output logic [X_W-1:0]         drw_x0,
    output logic [Y_W-1:0]         drw_y0,
    output logic [X_W-1:0]         drw_x1,
    output logic [Y_W-1:0]         drw_y1,
    output logic                   drw_color,
    input  logic                   drw_done,
    output logic                   busy,
    output logic                   timeout_err
);

    localparam int unsigned IDX_W = $clog2(NUM_REQ);

    if (NUM_REQ < 2 || TIMEOUT == 0) begin : g_bad_param
        $error("line_cmd_arbiter: NUM_REQ must be >= 2 and TIMEOUT > 0");
    end

    arb_state_e          state, state_nxt;
    logic [IDX_W-1:0]    ptr, ptr_nxt;
    logic [IDX_W-1:0]    win, win_nxt;
    logic [NUM_REQ-1:0]  win_oh, win_oh_nxt;
    logic [NUM_REQ-1:0]  ack_q, ack_nxt;
    line_cmd_t           cmd_q, cmd_nxt;
    logic                start_q, start_nxt;
    logic                busy_q, busy_nxt;
    logic                first_q, first_nxt;

    logic [NUM_REQ-1:0]  rr_grant;
    logic [IDX_W-1:0]    rr_idx;
    logic                rr_valid;

`ifdef LINE_ARB_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT) + 1;
    logic [CNT_W-1:0]    cnt, cnt_nxt;
    logic                terr, terr_nxt;
`endif

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
        .req   (req),
        .ptr   (ptr),
        .grant (rr_grant),
        .idx   (rr_idx),
        .valid (rr_valid)
    );

    // Next-state and next-output logic.
    always_comb begin
        state_nxt  = state;
        ptr_nxt    = ptr;
        win_nxt    = win;
        win_oh_nxt = win_oh;
        cmd_nxt    = cmd_q;
        first_nxt  = first_q;
`ifdef LINE_ARB_TIMEOUT_EN
        cnt_nxt    = cnt;
        terr_nxt   = terr;
`endif
        case (state)
            IDLE: begin
                if (rr_valid) begin
                    win_nxt    = rr_idx;
                    win_oh_nxt = rr_grant;
                    cmd_nxt    = req_cmd[rr_idx];
                    state_nxt  = START;
                end
            end
            START: begin
                first_nxt = 1'b1;
`ifdef LINE_ARB_TIMEOUT_EN
                cnt_nxt   = '0;
`endif
                state_nxt = DRAW;
            end
            DRAW: begin
                // First DRAW cycle may still see done from the previous line.
                first_nxt = 1'b0;
                if (drw_done && !first_q) begin
                    state_nxt = ACK;
                end
`ifdef LINE_ARB_TIMEOUT_EN
                else if (cnt == CNT_W'(TIMEOUT - 1)) begin
                    state_nxt = ACK;
                    terr_nxt  = 1'b1;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
`endif
            end
            ACK: begin
                ptr_nxt   = (win == IDX_W'(NUM_REQ - 1)) ? '0 : win + 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase

        // Registered outputs follow the state being entered.
        start_nxt = (state_nxt == START);
        busy_nxt  = (state_nxt != IDLE);
        ack_nxt   = (state_nxt == ACK) ? win_oh_nxt : '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            ptr     <= '0;
            win     <= '0;
            win_oh  <= '0;
            ack_q   <= '0;
            cmd_q   <= '0;
            start_q <= 1'b0;
            busy_q  <= 1'b0;
            first_q <= 1'b0;
        end else begin
            state   <= state_nxt;
            ptr     <= ptr_nxt;
            win     <= win_nxt;
            win_oh  <= win_oh_nxt;
            ack_q   <= ack_nxt;
            cmd_q   <= cmd_nxt;
            start_q <= start_nxt;
            busy_q  <= busy_nxt;
            first_q <= first_nxt;
        end
    end

`ifdef LINE_ARB_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt  <= '0;
            terr <= 1'b0;
        end else begin
            cnt  <= cnt_nxt;
            terr <= terr_nxt;
        end
    end
    assign timeout_err = terr;
`else
    assign timeout_err = 1'b0;
`endif

    assign ack       = ack_q;
    assign drw_start = start_q;
    assign busy      = busy_q;
    assign drw_x0    = X_W'(cmd_q.x0);
    assign drw_y0    = Y_W'(cmd_q.y0);
    assign drw_x1    = X_W'(cmd_q.x1);
    assign drw_y1    = Y_W'(cmd_q.y1);
    assign drw_color = cmd_q.color;

endmodule
